// File: rtl/soc_uart_pkg.sv
// Shared types and constants for the two-requester UART arbiter.
// Pure declarations: no latency, no backpressure.
package soc_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] UART_OFF_CMD  = 8'h00;
    localparam logic [7:0] UART_OFF_DATA = 8'h04;

    // Wide enough for any TIMEOUT in 1..255.
    localparam int TO_CNT_W = 8;

endpackage

// File: rtl/soc_uart_arb_if.sv
// Requester-side and UART-side signals of the arbiter; slave = arbiter view.
// No latency of its own; flow control is the req/ack and ce/rdy handshakes.
interface soc_uart_arb_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  oe0;
    logic                  we1;
    logic                  oe1;
    logic [7:0]            offset0;
    logic [7:0]            offset1;
    logic [7:0]            wdata0;
    logic [7:0]            wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  busy;
    logic                  u_ce;
    logic                  u_we;
    logic                  u_oe;
    logic [7:0]            u_offset;
    logic [7:0]            u_data_in;
    logic                  u_rdy;
    logic [DATA_WIDTH-1:0] u_data_out;

    modport slave (
        input  req0, req1, we0, oe0, we1, oe1,
        input  offset0, offset1, wdata0, wdata1,
        input  u_rdy, u_data_out,
        output ack0, ack1, rdata, err, busy,
        output u_ce, u_we, u_oe, u_offset, u_data_in
    );

    modport master (
        output req0, req1, we0, oe0, we1, oe1,
        output offset0, offset1, wdata0, wdata1,
        output u_rdy, u_data_out,
        input  ack0, ack1, rdata, err, busy,
        input  u_ce, u_we, u_oe, u_offset, u_data_in
    );
endinterface

// File: rtl/soc_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
// Combinational, zero latency; grants nothing while advance is low.
module soc_rr_arb2 (
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (advance) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/soc_uart_arb.sv
// Arbitrates two requesters onto one UART register port; all outputs registered.
// Latency: req -> u_ce 1 cycle -> ack 3 cycles; requesters stall (hold req) until ack, UART stalls via u_rdy up to TIMEOUT.
module soc_uart_arb
    import soc_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          rst,
    soc_uart_arb_if.slave bus
);

    localparam logic [TO_CNT_W-1:0] TO_VAL = TO_CNT_W'(TIMEOUT);

    state_t                r_state;
    logic [TO_CNT_W-1:0]   r_cnt;
    logic                  r_last;
    logic                  r_win;
    logic                  r_ack0;
    logic                  r_ack1;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  r_busy;
    logic                  r_u_ce;
    logic                  r_u_we;
    logic                  r_u_oe;
    logic [7:0]            r_u_offset;
    logic [7:0]            r_u_data_in;

    logic [1:0]            w_gnt;
    logic [TO_CNT_W-1:0]   w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + TO_CNT_W'(1);

    soc_rr_arb2 u_rr (
        .req     ({bus.req1, bus.req0}),
        .advance (r_state == ST_IDLE),
        .last    (r_last),
        .gnt     (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_win       <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_u_ce      <= 1'b0;
            r_u_we      <= 1'b0;
            r_u_oe      <= 1'b0;
            r_u_offset  <= '0;
            r_u_data_in <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // The u_* registers double as the latch for the winner's request.
                    if (w_gnt != 2'b00) begin
                        r_win       <= w_gnt[1];
                        r_last      <= w_gnt[1];
                        r_busy      <= 1'b1;
                        r_u_ce      <= 1'b1;
                        r_u_we      <= w_gnt[1] ? bus.we1     : bus.we0;
                        r_u_oe      <= w_gnt[1] ? bus.oe1     : bus.oe0;
                        r_u_offset  <= w_gnt[1] ? bus.offset1 : bus.offset0;
                        r_u_data_in <= w_gnt[1] ? bus.wdata1  : bus.wdata0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_u_ce      <= 1'b0;
                    r_u_we      <= 1'b0;
                    r_u_oe      <= 1'b0;
                    r_u_offset  <= '0;
                    r_u_data_in <= '0;
                    r_cnt       <= '0;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.u_rdy) begin
                        r_rdata <= bus.u_data_out;
                        r_err   <= 1'b0;
                        r_ack0  <= ~r_win;
                        r_ack1  <= r_win;
                        r_state <= ST_DONE;
                    end else if (w_cnt_nxt == TO_VAL) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_ack0  <= ~r_win;
                        r_ack1  <= r_win;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                ST_DONE: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.rdata     = r_rdata;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;
    assign bus.u_ce      = r_u_ce;
    assign bus.u_we      = r_u_we;
    assign bus.u_oe      = r_u_oe;
    assign bus.u_offset  = r_u_offset;
    assign bus.u_data_in = r_u_data_in;

endmodule

// File: tb/tb_soc_uart_arb.sv
// Directed vector bench for soc_uart_arb: table of transactions plus reset sequences.
module tb_soc_uart_arb;

    localparam int DW = 32;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    soc_uart_arb_if #(.DATA_WIDTH(DW)) bus ();

    soc_uart_arb #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]    req;        // {req1, req0}
        logic [1:0]    wo0;        // {we0, oe0}
        logic [1:0]    wo1;        // {we1, oe1}
        logic [7:0]    off0;
        logic [7:0]    wd0;
        logic [7:0]    off1;
        logic [7:0]    wd1;
        int            rdy_dly;    // WAIT cycles before u_rdy, -1 = never
        bit            rdy_early;  // u_rdy high during IDLE/ISSUE
        bit            drop;       // drop req after u_ce
        logic [DW-1:0] udata;
        logic [1:0]    e_gnt;      // expected {ack1, ack0}
        logic [1:0]    e_wo;       // expected {u_we, u_oe}
        logic [7:0]    e_off;
        logic [7:0]    e_wd;
        int            e_ack_lat;  // edges from u_ce to ack
        logic [DW-1:0] e_rdata;
        logic          e_err;
    } vec_t;

    vec_t vecs[13];

    task automatic do_txn(input int idx, input vec_t v);
        int lat;
        int k;
        bit got;
        bus.req0       = v.req[0];
        bus.req1       = v.req[1];
        {bus.we0, bus.oe0} = v.wo0;
        {bus.we1, bus.oe1} = v.wo1;
        bus.offset0    = v.off0;
        bus.wdata0     = v.wd0;
        bus.offset1    = v.off1;
        bus.wdata1     = v.wd1;
        bus.u_rdy      = v.rdy_early;
        bus.u_data_out = v.udata;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.u_ce && lat < 8);
        chk($sformatf("v%0d ce_lat", idx), 64'(lat), 64'd1);
        if (!bus.u_ce) return;
        chk($sformatf("v%0d busy_issue", idx), 64'(bus.busy), 64'd1);
        chk($sformatf("v%0d u_we_oe", idx), 64'({bus.u_we, bus.u_oe}), 64'(v.e_wo));
        chk($sformatf("v%0d u_offset", idx), 64'(bus.u_offset), 64'(v.e_off));
        chk($sformatf("v%0d u_data_in", idx), 64'(bus.u_data_in), 64'(v.e_wd));
        chk($sformatf("v%0d ack_early", idx), 64'({bus.ack1, bus.ack0}), 64'd0);
        if (v.drop) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d ce_pulse", idx), 64'({bus.u_ce, bus.u_we, bus.u_oe}), 64'd0);
        lat = 1;
        k = 0;
        got = 1'b0;
        bus.u_rdy = (v.rdy_dly == 0);
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.ack0 || bus.ack1) begin
                got = 1'b1;
            end else begin
                k++;
                bus.u_rdy = (v.rdy_dly >= 0 && k >= v.rdy_dly);
            end
        end
        chk($sformatf("v%0d ack_lat", idx), 64'(lat), 64'(v.e_ack_lat));
        chk($sformatf("v%0d ack_who", idx), 64'({bus.ack1, bus.ack0}), 64'(v.e_gnt));
        chk($sformatf("v%0d rdata", idx), 64'(bus.rdata), 64'(v.e_rdata));
        chk($sformatf("v%0d err", idx), 64'(bus.err), 64'(v.e_err));
        chk($sformatf("v%0d busy_done", idx), 64'(bus.busy), 64'd1);
        bus.u_rdy = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d ack_clear", idx), 64'({bus.ack1, bus.ack0}), 64'd0);
        chk($sformatf("v%0d idle_busy", idx), 64'(bus.busy), 64'd0);
        chk($sformatf("v%0d idle_rdata_err", idx), 64'({bus.rdata, bus.err}), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit seen;
        vecs[0]  = '{2'b01, 2'b01, 2'b00, 8'h04, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0, 32'h0000FFFF, 2'b01, 2'b01, 8'h04, 8'h00, 2, 32'h0000FFFF, 1'b0};
        vecs[1]  = '{2'b10, 2'b00, 2'b10, 8'h00, 8'h00, 8'h04, 8'h41, 0, 1'b0, 1'b0, 32'h00000000, 2'b10, 2'b10, 8'h04, 8'h41, 2, 32'h00000000, 1'b0};
        vecs[2]  = '{2'b11, 2'b01, 2'b10, 8'h00, 8'h00, 8'h04, 8'h55, 0, 1'b0, 1'b0, 32'h11111111, 2'b01, 2'b01, 8'h00, 8'h00, 2, 32'h11111111, 1'b0};
        vecs[3]  = '{2'b11, 2'b01, 2'b10, 8'h00, 8'h00, 8'h04, 8'h55, 0, 1'b0, 1'b0, 32'h22222222, 2'b10, 2'b10, 8'h04, 8'h55, 2, 32'h22222222, 1'b0};
        vecs[4]  = '{2'b11, 2'b01, 2'b10, 8'h00, 8'h00, 8'h04, 8'h55, 0, 1'b0, 1'b0, 32'h33333333, 2'b01, 2'b01, 8'h00, 8'h00, 2, 32'h33333333, 1'b0};
        vecs[5]  = '{2'b11, 2'b01, 2'b10, 8'h00, 8'h00, 8'h04, 8'h55, 0, 1'b0, 1'b0, 32'h44444444, 2'b10, 2'b10, 8'h04, 8'h55, 2, 32'h44444444, 1'b0};
        vecs[6]  = '{2'b01, 2'b01, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, -1, 1'b0, 1'b0, 32'hA5A5A5A5, 2'b01, 2'b01, 8'h00, 8'h00, 16, 32'h00000000, 1'b1};
        vecs[7]  = '{2'b10, 2'b00, 2'b11, 8'h00, 8'h00, 8'h08, 8'h7E, 0, 1'b0, 1'b0, 32'h12345678, 2'b10, 2'b11, 8'h08, 8'h7E, 2, 32'h12345678, 1'b0};
        vecs[8]  = '{2'b01, 2'b01, 2'b00, 8'h04, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1, 32'hCAFEF00D, 2'b01, 2'b01, 8'h04, 8'h00, 2, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{2'b10, 2'b00, 2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 3, 1'b1, 1'b0, 32'h0BADBEEF, 2'b10, 2'b01, 8'h00, 8'h00, 5, 32'h0BADBEEF, 1'b0};
        vecs[10] = '{2'b11, 2'b10, 2'b01, 8'h04, 8'h99, 8'h00, 8'h00, 0, 1'b0, 1'b0, 32'h00000077, 2'b01, 2'b10, 8'h04, 8'h99, 2, 32'h00000077, 1'b0};
        vecs[11] = '{2'b11, 2'b10, 2'b01, 8'h04, 8'h99, 8'h00, 8'h00, 0, 1'b0, 1'b0, 32'h00000088, 2'b01, 2'b10, 8'h04, 8'h99, 2, 32'h00000088, 1'b0};
        vecs[12] = '{2'b10, 2'b00, 2'b01, 8'h00, 8'h00, 8'h04, 8'h00, 0, 1'b0, 1'b0, 32'h0000ABCD, 2'b10, 2'b01, 8'h04, 8'h00, 2, 32'h0000ABCD, 1'b0};

        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.we0 = 1'b0; bus.oe0 = 1'b0; bus.we1 = 1'b0; bus.oe1 = 1'b0;
        bus.offset0 = '0; bus.offset1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.u_rdy = 1'b0; bus.u_data_out = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", 64'({bus.ack1, bus.ack0, bus.err, bus.busy, bus.u_ce, bus.u_we, bus.u_oe}), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        chk("rst_u_bus", 64'({bus.u_offset, bus.u_data_in}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i <= 10; i++) do_txn(i, vecs[i]);

        // Reset during WAIT: transaction abandoned, no ack.
        bus.req0 = 1'b1; bus.req1 = 1'b0;
        bus.we0 = 1'b0; bus.oe0 = 1'b1; bus.offset0 = 8'h04;
        bus.u_rdy = 1'b0;
        @(posedge clk); #1;
        chk("mr_ce", 64'(bus.u_ce), 64'd1);
        @(posedge clk); #1;
        chk("mr_busy_wait", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        bus.req0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mr_rst_outs", 64'({bus.ack1, bus.ack0, bus.err, bus.busy, bus.u_ce}), 64'd0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.ack0 || bus.ack1) seen = 1'b1;
        end
        chk("mr_no_ack", 64'(seen), 64'd0);
        chk("mr_busy_after", 64'(bus.busy), 64'd0);

        do_txn(11, vecs[11]);
        do_txn(12, vecs[12]);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
